hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard and stall controller for the 5-stage MIPS core.
//   Generates the ID-stage branch forwarding selects (forwardAD/BD) and
//   the EX forwarding selects. Detects load-use and branch-operand hazards
//   and sequences whole-pipeline freezes while inst/data SRAM accesses are
//   outstanding. Sits beside id/ex/mem, drives their stall/flush inputs.
// PARAMETERS
//   MEM_TIMEOUT  255  max consecutive wait cycles before sticky mem_timeout
//   CNT_WIDTH    32   width of the stall_cycles performance counter
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous, active-low reset
//   rsD, rtD       in   5   source regs of instruction in ID
//   rsE, rtE       in   5   source regs of instruction in EX
//   npcOpD         in   `NPC_OP_LENGTH   next-PC op of ID instr (branch/jr use regs)
//   writeRegAddrE  in   5   dest reg in EX;  Regfile_weE in 1  its write enable
//   regSrc_muxE    in   `REG_SRC_LENGTH  EX writeback source (`REG_SRC_MEM = load)
//   writeRegAddrM  in   5   dest reg in MEM; Regfile_weM in 1; regSrc_muxM in `REG_SRC_LENGTH
//   writeRegAddrW  in   5   dest reg in WB;  Regfile_weW in 1
//   inst_req       in   1   IF issuing an instruction fetch this cycle
//   inst_ok        in   1   instruction SRAM data valid this cycle
//   data_req       in   1   MEM issuing a load/store this cycle
//   data_ok        in   1   data SRAM access complete this cycle
//   forwardAD/BD   out  1   ID compare operand from aluOutM
//   forwardAE/BE   out  2   EX operand: `FWD_REG / `FWD_WB / `FWD_MEM
//   stallF,stallD,stallE,stallM  out 1  hold stage register
//   flushD, flushE out  1   load bubble (nop) into stage register
//   mem_timeout    out  1   sticky: a wait exceeded MEM_TIMEOUT cycles
//   stall_cycles   out  CNT_WIDTH  count of cycles with stallF asserted
// BEHAVIOUR
//   Reset (rst=0): state=RUN, wait counter=0, stall_cycles=0, mem_timeout=0;
//     all combinational outputs evaluate to 0 / `FWD_REG (no req while reset).
//   Reg 0 never matches: every match below requires addr!=0 and its we=1.
//   forwardAD = weM & wM==rsD; forwardBD likewise with rtD.
//   forwardAE: wM==rsE -> `FWD_MEM; else wW==rsE -> `FWD_WB; else `FWD_REG
//     (MEM has priority over WB). forwardBE likewise with rtE.
//   lu_stall = load in EX & wE in {rsD,rtD}.
//   br_stall = npcOpD is branch/jr & (weE & wE in {rsD,rtD}
//     | load in MEM & wM in {rsD,rtD}).
//   lu_stall|br_stall -> stallF=stallD=1, flushE=1 (one bubble per cycle).
//   Memory FSM (mem_wait_fsm), states RUN, WAIT_I, WAIT_D, WAIT_ID:
//     i_pend = (inst_req & !inst_ok) | state in {WAIT_I,WAIT_ID} & !inst_ok
//     d_pend = (data_req & !data_ok) | state in {WAIT_D,WAIT_ID} & !data_ok
//     next state encodes {i_pend,d_pend}; ok completes in same cycle it arrives.
//     Outstanding access persists even if req drops (flushed fetch still drains).
//   d_pend -> stallF=stallD=stallE=stallM=1, flushE=0 (full freeze; WB proceeds).
//   i_pend & !d_pend -> stallF=1, flushD=1 (bubble into ID, EX/MEM advance).
//   d_pend overrides hazard bubble: while frozen flushE=0, hazard re-evaluated after.
//   i_pend with lu/br_stall: stallF=stallD=1, flushE=1, flushD=0 (ID holds).
//   Wait counter: +1 each cycle state!=RUN, cleared in RUN; reaching
//     MEM_TIMEOUT sets mem_timeout until reset. Saturates, never wraps.
//   stall_cycles: +1 per cycle stallF=1; wraps modulo 2^CNT_WIDTH.
//   All stall/flush/forward outputs combinational from inputs+state (0-cycle).
// STRUCTURE
//   defines.vh: `FWD_REG=2'b00, `FWD_WB=2'b01, `FWD_MEM=2'b10, FSM state codes,
//     `REG_SRC_MEM, branch/jr `NPC_OP codes.
//   Sub-module mem_wait_fsm: state reg, wait counter, timeout flag, i/d_pend.
// TESTING
//   lw $2 in EX, beq $2,$3 in ID -> stallF=stallD=flushE=1 one cycle, then
//     load in MEM -> still stalled; next cycle forwardAD=0, no stall.
//   add wM=$5, add wW=$5, rsE=$5 -> forwardAE=`FWD_MEM; rsE=$0, wM=$0 -> `FWD_REG.
//   data_req=1, data_ok after 3 cycles -> all stalls=1 for 3 cycles, 0 on 4th.
//   inst_req=1, inst_ok=0 then req dropped -> state WAIT_I held until inst_ok.
//   inst and data both pending, data_ok first -> WAIT_ID->WAIT_I, full freeze ends.
//   data_ok withheld 256 cycles (MEM_TIMEOUT=255) -> mem_timeout=1, stays after
//     ok; rst=0 mid-wait -> RUN, mem_timeout=0, stall_cycles=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, next-PC and
// writeback-source codes, memory-wait FSM states and a register-match helper.
package hazard_ctrl_pkg;

  localparam int NPC_OP_LENGTH  = 3;
  localparam int REG_SRC_LENGTH = 2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_NEXT   = 3'd0;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JUMP   = 3'd1;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_BRANCH = 3'd2;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JR     = 3'd3;

  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_ALU = 2'd0;
  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM = 2'd1;
  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_PC  = 2'd2;

  // State bits are {inst outstanding, data outstanding}.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_D  = 2'b01,
    WAIT_I  = 2'b10,
    WAIT_ID = 2'b11
  } memState_t;

  // $0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic regHit(input logic [4:0] dst, input logic we, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Tracks outstanding instruction/data SRAM accesses, counts consecutive wait
// cycles and raises a sticky timeout flag when a wait runs too long.
module mem_wait_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic inst_ok,
  input  logic data_req,
  input  logic data_ok,
  output logic iPend,
  output logic dPend,
  output logic memTimeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

  memState_t   state;
  logic [CW-1:0] waitCnt;
  logic        iOutstanding;
  logic        dOutstanding;

  assign iOutstanding = (state == WAIT_I) || (state == WAIT_ID);
  assign dOutstanding = (state == WAIT_D) || (state == WAIT_ID);

  // An ok completes the access in the cycle it arrives, even a fresh request.
  assign iPend = (inst_req || iOutstanding) && !inst_ok;
  assign dPend = (data_req || dOutstanding) && !data_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      state <= memState_t'({iPend, dPend});
      if (state == RUN) begin
        waitCnt <= '0;
      end else if (waitCnt != WAIT_MAX) begin
        waitCnt <= waitCnt + 1'b1;
      end
      // Set on the edge where the counter lands on the limit.
      if ((state != RUN) && (waitCnt >= WAIT_MAX - 1'b1)) begin
        memTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects for ID and EX, load-use
// and branch-operand stalls, and freezes while SRAM accesses are outstanding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                rsD,
  input  logic [4:0]                rtD,
  input  logic [4:0]                rsE,
  input  logic [4:0]                rtE,
  input  logic [NPC_OP_LENGTH-1:0]  npcOpD,
  input  logic [4:0]                writeRegAddrE,
  input  logic                      Regfile_weE,
  input  logic [REG_SRC_LENGTH-1:0] regSrc_muxE,
  input  logic [4:0]                writeRegAddrM,
  input  logic                      Regfile_weM,
  input  logic [REG_SRC_LENGTH-1:0] regSrc_muxM,
  input  logic [4:0]                writeRegAddrW,
  input  logic                      Regfile_weW,
  input  logic                      inst_req,
  input  logic                      inst_ok,
  input  logic                      data_req,
  input  logic                      data_ok,
  output logic                      forwardAD,
  output logic                      forwardBD,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      stallE,
  output logic                      stallM,
  output logic                      flushD,
  output logic                      flushE,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  logic iPend, dPend;
  logic loadE, loadM, branchD;
  logic hitED, hitMD, luStall, brStall;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_memWait (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_ok    (inst_ok),
    .data_req   (data_req),
    .data_ok    (data_ok),
    .iPend      (iPend),
    .dPend      (dPend),
    .memTimeout (mem_timeout)
  );

  assign forwardAD = regHit(writeRegAddrM, Regfile_weM, rsD);
  assign forwardBD = regHit(writeRegAddrM, Regfile_weM, rtD);

  always_comb begin
    forwardAE = FWD_REG;
    if (regHit(writeRegAddrM, Regfile_weM, rsE))      forwardAE = FWD_MEM;
    else if (regHit(writeRegAddrW, Regfile_weW, rsE)) forwardAE = FWD_WB;
    forwardBE = FWD_REG;
    if (regHit(writeRegAddrM, Regfile_weM, rtE))      forwardBE = FWD_MEM;
    else if (regHit(writeRegAddrW, Regfile_weW, rtE)) forwardBE = FWD_WB;
  end

  assign loadE   = regSrc_muxE == REG_SRC_MEM;
  assign loadM   = regSrc_muxM == REG_SRC_MEM;
  assign branchD = (npcOpD == NPC_OP_BRANCH) || (npcOpD == NPC_OP_JR);
  assign hitED   = regHit(writeRegAddrE, Regfile_weE, rsD) || regHit(writeRegAddrE, Regfile_weE, rtD);
  assign hitMD   = regHit(writeRegAddrM, Regfile_weM, rsD) || regHit(writeRegAddrM, Regfile_weM, rtD);
  assign luStall = loadE && hitED;
  assign brStall = branchD && (hitED || (loadM && hitMD));

  // Data wait freezes everything; a hazard bubble beats an instruction bubble.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (dPend) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (luStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (iPend) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stallF) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random stimulus for hazard_ctrl, checked cycle by cycle against
// a behavioural model of the dependency rules and the memory-wait bookkeeping.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MEM_TO = 255;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
  logic [NPC_OP_LENGTH-1:0] npcOpD;
  logic weE, weM, weW;
  logic [REG_SRC_LENGTH-1:0] srcE, srcM;
  logic inst_req, inst_ok, data_req, data_ok;
  logic forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
  logic [1:0] forwardAE, forwardBE;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Model: which accesses are outstanding, consecutive wait length, sticky flag, stall count.
  bit mInst, mData, mTo;
  int mWait;
  logic [31:0] mStalls;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .npcOpD(npcOpD),
    .writeRegAddrE(wE), .Regfile_weE(weE), .regSrc_muxE(srcE),
    .writeRegAddrM(wM), .Regfile_weM(weM), .regSrc_muxM(srcM),
    .writeRegAddrW(wW), .Regfile_weW(weW),
    .inst_req(inst_req), .inst_ok(inst_ok), .data_req(data_req), .data_ok(data_ok),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] dst, input logic we, input logic [4:0] src);
    return we && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] exFwd(input logic [4:0] src);
    if (dep(wM, weM, src)) return FWD_MEM;
    if (dep(wW, weW, src)) return FWD_WB;
    return FWD_REG;
  endfunction

  task automatic clearIns();
    {rsD, rtD, rsE, rtE, wE, wM, wW} = '0;
    {weE, weM, weW} = '0;
    npcOpD = NPC_OP_NEXT; srcE = REG_SRC_ALU; srcM = REG_SRC_ALU;
    {inst_req, inst_ok, data_req, data_ok} = '0;
  endtask

  task automatic modelReset();
    mInst = 0; mData = 0; mTo = 0; mWait = 0; mStalls = '0;
  endtask

  // Check the current cycle, advance one clock, update the model.
  task automatic step(input string tag);
    bit ip, dp, haz, br;
    bit eSF, eSD, eSE, eSM, eFD, eFE;
    #1;
    ip  = (inst_req || mInst) && !inst_ok;
    dp  = (data_req || mData) && !data_ok;
    br  = (npcOpD == NPC_OP_BRANCH || npcOpD == NPC_OP_JR) &&
          (dep(wE, weE, rsD) || dep(wE, weE, rtD) ||
           (srcM == REG_SRC_MEM && (dep(wM, weM, rsD) || dep(wM, weM, rtD))));
    haz = br || (srcE == REG_SRC_MEM && (dep(wE, weE, rsD) || dep(wE, weE, rtD)));
    eSF = dp || haz || ip;
    eSD = dp || haz;
    eSE = dp;
    eSM = dp;
    eFE = !dp && haz;
    eFD = !dp && !haz && ip;
    chk({tag, ".forwardAD"}, forwardAD, dep(wM, weM, rsD));
    chk({tag, ".forwardBD"}, forwardBD, dep(wM, weM, rtD));
    chk({tag, ".forwardAE"}, forwardAE, exFwd(rsE));
    chk({tag, ".forwardBE"}, forwardBE, exFwd(rtE));
    chk({tag, ".stallF"}, stallF, eSF);
    chk({tag, ".stallD"}, stallD, eSD);
    chk({tag, ".stallE"}, stallE, eSE);
    chk({tag, ".stallM"}, stallM, eSM);
    chk({tag, ".flushD"}, flushD, eFD);
    chk({tag, ".flushE"}, flushE, eFE);
    chk({tag, ".mem_timeout"}, mem_timeout, mTo);
    chk({tag, ".stall_cycles"}, stall_cycles, mStalls);
    $display("step %s: stallF=%0b stallD=%0b flushD=%0b flushE=%0b fwdAE=%0d stalls=%0d",
             tag, stallF, stallD, flushD, flushE, forwardAE, stall_cycles);
    @(posedge clk);
    if (mInst || mData) begin
      if (mWait < MEM_TO) mWait++;
      if (mWait >= MEM_TO) mTo = 1;
    end else begin
      mWait = 0;
    end
    mInst = ip;
    mData = dp;
    if (eSF) mStalls = mStalls + 1;
    @(negedge clk);
  endtask

  initial begin
    clearIns();
    rst = 1'b0;
    modelReset();
    #1;
    chk("reset.stall_cycles", stall_cycles, 32'd0);
    chk("reset.mem_timeout", mem_timeout, 1'b0);
    chk("reset.stallF", stallF, 1'b0);
    chk("reset.forwardAE", forwardAE, FWD_REG);
    @(negedge clk);
    rst = 1'b1;
    step("idle");

    // lw $2 in EX, beq $2,$3 in ID; then load in MEM; then load in WB.
    rsD = 5'd2; rtD = 5'd3; npcOpD = NPC_OP_BRANCH;
    wE = 5'd2; weE = 1; srcE = REG_SRC_MEM;
    step("lu_ex");
    wE = 5'd0; weE = 0; srcE = REG_SRC_ALU;
    wM = 5'd2; weM = 1; srcM = REG_SRC_MEM;
    step("lu_mem");
    wM = 5'd0; weM = 0; srcM = REG_SRC_ALU; wW = 5'd2; weW = 1;
    step("lu_wb");

    // Forwarding priority and the $0 exclusion.
    clearIns();
    wM = 5'd5; weM = 1; wW = 5'd5; weW = 1; rsE = 5'd5; rtE = 5'd5;
    step("fwd_mem");
    wM = 5'd7; rtE = 5'd0;
    step("fwd_wb");
    rsE = 5'd0; wM = 5'd0; wW = 5'd0;
    step("fwd_zero");

    // Data access completing three cycles after the request.
    clearIns();
    data_req = 1;
    step("d_req");
    data_req = 0;
    step("d_wait1");
    step("d_wait2");
    data_ok = 1;
    step("d_ok");
    data_ok = 0;
    step("d_after");

    // Fetch dropped while outstanding still drains until inst_ok.
    inst_req = 1;
    step("i_req");
    inst_req = 0;
    for (int i = 0; i < 3; i++) step("i_drain");
    rsD = 5'd4; npcOpD = NPC_OP_JR; wE = 5'd4; weE = 1;
    step("i_with_hazard");
    clearIns();
    inst_ok = 1;
    step("i_ok");
    inst_ok = 0;
    step("i_after");

    // Both outstanding, data completes first.
    inst_req = 1; data_req = 1;
    step("id_req");
    inst_req = 0; data_req = 0;
    step("id_wait");
    data_ok = 1;
    step("id_dok");
    data_ok = 0;
    step("id_iwait");
    inst_ok = 1;
    step("id_iok");
    inst_ok = 0;

    // Long data wait trips the sticky timeout.
    data_req = 1;
    step("to_req");
    data_req = 0;
    for (int i = 0; i < 260; i++) step("to_wait");
    data_ok = 1;
    step("to_ok");
    data_ok = 0;
    for (int i = 0; i < 3; i++) step("to_sticky");

    // Asynchronous reset in the middle of a wait.
    data_req = 1;
    step("rst_req");
    data_req = 0;
    step("rst_wait");
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    chk("midrst.stall_cycles", stall_cycles, 32'd0);
    chk("midrst.mem_timeout", mem_timeout, 1'b0);
    chk("midrst.stallF", stallF, 1'b0);
    chk("midrst.stallM", stallM, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      wE = 5'($urandom_range(0, 3)); wM = 5'($urandom_range(0, 3)); wW = 5'($urandom_range(0, 3));
      weE = 1'($urandom_range(0, 1)); weM = 1'($urandom_range(0, 1)); weW = 1'($urandom_range(0, 1));
      srcE = 2'($urandom_range(0, 2)); srcM = 2'($urandom_range(0, 2));
      npcOpD = 3'($urandom_range(0, 3));
      inst_req = ($urandom_range(0, 3) == 0);
      inst_ok  = ($urandom_range(0, 1) == 0);
      data_req = ($urandom_range(0, 3) == 0);
      data_ok  = ($urandom_range(0, 1) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
